// File: rtl/garuda_wbuf_pkg.sv
// Shared definitions for the Garuda weight buffer and its fetch sequencer.
package garuda_wbuf_pkg;

    localparam int WBUF_NUM_BANKS       = 4;
    localparam int WBUF_DATA_WIDTH      = 32;
    localparam int WBUF_BANK_ADDR_WIDTH = 13;

    typedef enum logic [1:0] {
        WF_IDLE,
        WF_FETCH,
        WF_DRAIN,
        WF_DONE
    } wfetch_state_e;

endpackage

// File: rtl/wfetch_beat_fifo.sv
// Small synchronous FIFO holding fetched beats; head is visible combinationally.
module wfetch_beat_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch sequencer: reads one word from every bank per beat and streams
// the beats to the consumer through a small FIFO.
module weight_fetch_ctrl
    import garuda_wbuf_pkg::*;
#(
    parameter int BANK_ADDR_WIDTH = WBUF_BANK_ADDR_WIDTH,
    parameter int DATA_WIDTH      = WBUF_DATA_WIDTH,
    parameter int NUM_BANKS       = WBUF_NUM_BANKS,
    parameter int LEN_WIDTH       = 14,
    parameter int FIFO_DEPTH      = 4,
    localparam int BANK_SEL_W     = $clog2(NUM_BANKS),
    localparam int RD_ADDR_W      = BANK_ADDR_WIDTH + BANK_SEL_W
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    start_i,
    input  logic [BANK_ADDR_WIDTH-1:0]              base_off_i,
    input  logic [LEN_WIDTH-1:0]                    num_beats_i,
    input  logic                                    abort_i,
    output logic                                    busy_o,
    output logic                                    done_o,
    output logic                                    err_o,
    output logic [NUM_BANKS-1:0]                    rd_en_o,
    output logic [NUM_BANKS-1:0][RD_ADDR_W-1:0]     rd_addr_o,
    input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]    rd_data_i,
    input  logic [NUM_BANKS-1:0]                    rd_valid_i,
    output logic                                    w_valid_o,
    input  logic                                    w_ready_i,
    output logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]    w_data_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = ((LEN_WIDTH > BANK_ADDR_WIDTH) ? LEN_WIDTH : BANK_ADDR_WIDTH) + 1;

    wfetch_state_e              state_q;
    logic [BANK_ADDR_WIDTH-1:0] cur_off_q;
    logic [LEN_WIDTH-1:0]       remaining_q;
    logic                       err_q;

    logic                       fifo_full;
    logic                       fifo_empty;
    logic [CNT_W-1:0]           fifo_count;
    logic                       in_job;
    logic                       pop;
    logic                       rd_issue;
    logic                       rd_ok;
    logic                       push;
    logic                       flush;
    logic [SUM_W-1:0]           end_off;
    logic                       range_err;

    assign in_job    = (state_q == WF_FETCH) || (state_q == WF_DRAIN);
    assign w_valid_o = !fifo_empty && !rst_i;
    assign pop       = w_valid_o && w_ready_i;
    assign rd_issue  = (state_q == WF_FETCH) && !abort_i && !rst_i && (!fifo_full || pop);
    assign rd_ok     = &rd_valid_i;
    assign push      = rd_issue && rd_ok;
    assign flush     = abort_i && in_job;

    assign end_off   = SUM_W'(base_off_i) + SUM_W'(num_beats_i);
    assign range_err = end_off > (SUM_W'(1) << BANK_ADDR_WIDTH);

    assign rd_en_o = {NUM_BANKS{rd_issue}};
    assign busy_o  = in_job && !rst_i;
    assign done_o  = (state_q == WF_DONE) && !rst_i;
    assign err_o   = err_q && !rst_i;

    // Each port carries its own bank number in the upper address bits.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_addr
        assign rd_addr_o[b] = {BANK_SEL_W'(b), cur_off_q};
    end

    wfetch_beat_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NUM_BANKS * DATA_WIDTH)
    ) u_beat_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (rd_data_i),
        .pop_i       (pop),
        .head_o      (w_data_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= WF_IDLE;
            cur_off_q   <= '0;
            remaining_q <= '0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                WF_IDLE: begin
                    if (start_i && !abort_i) begin
                        err_q       <= 1'b0;
                        cur_off_q   <= base_off_i;
                        remaining_q <= num_beats_i;
                        if (num_beats_i == '0) begin
                            state_q <= WF_DONE;
                        end else if (range_err) begin
                            err_q   <= 1'b1;
                            state_q <= WF_DONE;
                        end else begin
                            state_q <= WF_FETCH;
                        end
                    end
                end
                WF_FETCH: begin
                    if (abort_i) begin
                        state_q <= WF_IDLE;
                    end else if (rd_issue) begin
                        if (!rd_ok) begin
                            err_q   <= 1'b1;
                            state_q <= WF_DRAIN;
                        end else begin
                            cur_off_q   <= cur_off_q + BANK_ADDR_WIDTH'(1);
                            remaining_q <= remaining_q - LEN_WIDTH'(1);
                            if (remaining_q == LEN_WIDTH'(1)) state_q <= WF_DRAIN;
                        end
                    end
                end
                WF_DRAIN: begin
                    if (abort_i) begin
                        state_q <= WF_IDLE;
                    end else if (fifo_count == '0) begin
                        state_q <= WF_DONE;
                    end
                end
                WF_DONE: state_q <= WF_IDLE;
                default: state_q <= WF_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: directed job table, corner sequences and random jobs.
module tb_weight_fetch_ctrl;

    localparam int AW  = 13;
    localparam int DW  = 32;
    localparam int NB  = 4;
    localparam int LW  = 14;
    localparam int FD  = 4;
    localparam int FAW = AW + 2;

    logic                   clk_i = 1'b0;
    logic                   rst_i, start_i, abort_i, w_ready_i;
    logic [AW-1:0]          base_off_i;
    logic [LW-1:0]          num_beats_i;
    logic                   busy_o, done_o, err_o, w_valid_o;
    logic [NB-1:0]          rd_en_o, rd_valid_i;
    logic [NB-1:0][FAW-1:0] rd_addr_o;
    logic [NB-1:0][DW-1:0]  rd_data_i, w_data_o;

    int n_checks = 0;
    int n_pass   = 0;

    int obs_err, obs_beats, obs_reads, reads_at_hold;
    int c_first_read, c_last_read, c_first_valid, c_last_beat, c_done;

    weight_fetch_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_off_i  (base_off_i),
        .num_beats_i (num_beats_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rd_en_o     (rd_en_o),
        .rd_addr_o   (rd_addr_o),
        .rd_data_i   (rd_data_i),
        .rd_valid_i  (rd_valid_i),
        .w_valid_o   (w_valid_o),
        .w_ready_i   (w_ready_i),
        .w_data_o    (w_data_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] word_at(input int full_addr);
        return (32'(full_addr) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [FAW-1:0] exp_addr(input int b, input int off);
        return FAW'((b << AW) | off);
    endfunction

    function automatic logic [NB*DW-1:0] exp_beat(input int off);
        logic [NB*DW-1:0] r;
        for (int b = 0; b < NB; b++) r[b*DW +: DW] = word_at((b << AW) | off);
        return r;
    endfunction

    // The weight buffer: every address holds a distinct, address-derived word.
    always_comb begin
        for (int b = 0; b < NB; b++) rd_data_i[b] = word_at(int'(rd_addr_o[b]));
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // mode 0: ready held high, 1: random ready, 2: ready low for `hold` cycles then high.
    task automatic run_job(input int base, input int num, input int bad_idx,
                           input int mode, input int hold);
        int  q[$];
        int  occ;
        int  exp_off;
        bit  fetching;
        bit  exp_rd;
        occ = 0;
        exp_off = base;
        obs_err = 0; obs_beats = 0; obs_reads = 0; reads_at_hold = 0;
        c_first_read = -1; c_last_read = -1; c_first_valid = -1; c_last_beat = -1; c_done = -1;
        fetching = (num > 0) && (base + num <= (1 << AW));
        base_off_i  = AW'(base);
        num_beats_i = LW'(num);
        start_i     = 1'b1;
        w_ready_i   = 1'b0;
        rd_valid_i  = '1;
        #1;
        tick();
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 400 && c_done < 0; cyc++) begin
            case (mode)
                0:       w_ready_i = 1'b1;
                1:       w_ready_i = 1'($urandom_range(0, 1));
                default: w_ready_i = (cyc > hold);
            endcase
            rd_valid_i = (obs_reads == bad_idx) ? 4'b1011 : 4'b1111;
            #1;
            exp_rd = fetching && (occ < FD || (occ > 0 && w_ready_i));
            chk("w_valid", 128'(w_valid_o), 128'(occ > 0));
            chk("rd_en", 128'(rd_en_o), exp_rd ? 128'hF : 128'h0);
            if (w_valid_o && c_first_valid < 0) c_first_valid = cyc;
            if (w_valid_o && w_ready_i) begin
                if (q.size() == 0) begin
                    chk("spurious_beat", 128'(w_valid_o), 128'(0));
                end else begin
                    chk("beat_data", 128'(w_data_o), 128'(exp_beat(q[0])));
                    void'(q.pop_front());
                    occ--;
                end
                obs_beats++;
                c_last_beat = cyc;
            end
            if (rd_en_o != '0) begin
                for (int b = 0; b < NB; b++)
                    chk("rd_addr", 128'(rd_addr_o[b]), 128'(exp_addr(b, exp_off)));
                obs_reads++;
                if (c_first_read < 0) c_first_read = cyc;
                c_last_read = cyc;
                if (&rd_valid_i) begin
                    q.push_back(exp_off);
                    exp_off++;
                    occ++;
                    if (obs_reads >= num) fetching = 1'b0;
                end else begin
                    fetching = 1'b0;
                end
            end
            if (cyc <= hold) reads_at_hold = obs_reads;
            if (done_o) begin
                c_done  = cyc;
                obs_err = int'(err_o);
            end
            tick();
        end
        if (c_done < 0) begin
            chk("done_timeout", 128'(done_o), 128'(1));
        end else begin
            #1;
            chk("done_one_cycle", 128'(done_o), 128'(0));
            chk("idle_after_done", 128'(busy_o), 128'(0));
        end
    endtask

    typedef struct {
        int base;
        int num;
        int bad;
        int mode;
        int hold;
        int exp_err;
        int exp_beats;
        int exp_reads;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{'h10,   3,  -1, 0, 0,  0, 3,  3};
        tbl[1] = '{'h1FFE, 3,  -1, 0, 0,  1, 0,  0};
        tbl[2] = '{'h1FFD, 3,  -1, 1, 0,  0, 3,  3};
        tbl[3] = '{'h55,   0,  -1, 0, 0,  0, 0,  0};
        tbl[4] = '{'h200,  5,   1, 0, 0,  1, 1,  2};
        tbl[5] = '{0,      1,  -1, 0, 0,  0, 1,  1};
        tbl[6] = '{'h700,  8,  -1, 2, 10, 0, 8,  8};
        tbl[7] = '{'h1000, 9,   0, 1, 0,  1, 0,  1};
        tbl[8] = '{'h1FF0, 16, -1, 1, 0,  0, 16, 16};

        rst_i = 1'b1; start_i = 1'b1; abort_i = 1'b0; w_ready_i = 1'b0;
        base_off_i = '0; num_beats_i = LW'(4); rd_valid_i = '1;
        tick(); tick(); tick();
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_done", 128'(done_o), 128'(0));
        chk("rst_err", 128'(err_o), 128'(0));
        chk("rst_rd_en", 128'(rd_en_o), 128'(0));
        chk("rst_w_valid", 128'(w_valid_o), 128'(0));
        rst_i = 1'b0; start_i = 1'b0;
        tick();
        chk("rst_start_ignored", 128'(busy_o), 128'(0));

        for (int i = 0; i < 9; i++) begin
            run_job(tbl[i].base, tbl[i].num, tbl[i].bad, tbl[i].mode, tbl[i].hold);
            chk($sformatf("tbl%0d_err", i), 128'(obs_err), 128'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_beats", i), 128'(obs_beats), 128'(tbl[i].exp_beats));
            chk($sformatf("tbl%0d_reads", i), 128'(obs_reads), 128'(tbl[i].exp_reads));
            if (i == 0) begin
                chk("back_to_back_reads", 128'(c_last_read - c_first_read), 128'(2));
                chk("read_to_valid_latency", 128'(c_first_valid - c_first_read), 128'(1));
                chk("done_after_last_beat", 128'(c_done - c_last_beat), 128'(2));
            end
            if (i == 1) chk("range_err_done_latency", 128'(c_done), 128'(1));
            if (i == 6) chk("reads_while_stalled", 128'(reads_at_hold), 128'(FD));
        end

        // Abort in the third FETCH cycle.
        abort_i = 1'b0; w_ready_i = 1'b1; rd_valid_i = '1;
        base_off_i = AW'('h40); num_beats_i = LW'(10); start_i = 1'b1;
        #1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        abort_i = 1'b1;
        #1;
        chk("abort_blocks_read", 128'(rd_en_o), 128'(0));
        tick();
        abort_i = 1'b0;
        chk("abort_busy", 128'(busy_o), 128'(0));
        chk("abort_w_valid", 128'(w_valid_o), 128'(0));
        for (int k = 0; k < 4; k++) begin
            chk("abort_no_done", 128'(done_o), 128'(0));
            tick();
        end
        run_job('h20, 4, -1, 0, 0);
        chk("post_abort_err", 128'(obs_err), 128'(0));
        chk("post_abort_beats", 128'(obs_beats), 128'(4));

        // Reset while draining a full FIFO, with start held during reset.
        base_off_i = AW'('h100); num_beats_i = LW'(4); start_i = 1'b1; w_ready_i = 1'b0;
        #1;
        tick();
        start_i = 1'b0;
        tick(); tick(); tick(); tick();
        chk("drain_busy", 128'(busy_o), 128'(1));
        chk("drain_w_valid", 128'(w_valid_o), 128'(1));
        rst_i = 1'b1; start_i = 1'b1;
        tick();
        chk("midrst_busy", 128'(busy_o), 128'(0));
        chk("midrst_done", 128'(done_o), 128'(0));
        chk("midrst_err", 128'(err_o), 128'(0));
        chk("midrst_rd_en", 128'(rd_en_o), 128'(0));
        chk("midrst_w_valid", 128'(w_valid_o), 128'(0));
        tick();
        rst_i = 1'b0; start_i = 1'b0;
        tick();
        chk("postrst_busy", 128'(busy_o), 128'(0));
        chk("postrst_w_valid", 128'(w_valid_o), 128'(0));
        chk("postrst_done", 128'(done_o), 128'(0));

        // Random jobs against the job-level rules.
        for (int j = 0; j < 30; j++) begin
            int base, num, bad, e_err, e_beats, e_reads;
            base = ($urandom_range(0, 1) == 1) ? (8192 - int'($urandom_range(1, 12)))
                                               : int'($urandom_range(0, 8191));
            num  = int'($urandom_range(0, 12));
            bad  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, num)) : -1;
            if (num == 0) begin
                e_err = 0; e_beats = 0; e_reads = 0;
            end else if (base + num > 8192) begin
                e_err = 1; e_beats = 0; e_reads = 0;
            end else if (bad >= 0 && bad < num) begin
                e_err = 1; e_beats = bad; e_reads = bad + 1;
            end else begin
                e_err = 0; e_beats = num; e_reads = num;
            end
            run_job(base, num, bad, 1, 0);
            chk($sformatf("rnd%0d_err", j), 128'(obs_err), 128'(e_err));
            chk($sformatf("rnd%0d_beats", j), 128'(obs_beats), 128'(e_beats));
            chk($sformatf("rnd%0d_reads", j), 128'(obs_reads), 128'(e_reads));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/weight_fetch_ctrl.md
WEIGHT_FETCH_CTRL -- requirements
Module: weight_fetch_ctrl

Interface
REQ-001 SHALL have parameter BANK_ADDR_WIDTH, default 13, meaning the per-bank word offset width (8192 words per bank).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the weight word width.
REQ-003 SHALL have parameter NUM_BANKS, default 4, meaning the number of weight buffer banks, all read in parallel.
REQ-004 SHALL have parameter LEN_WIDTH, default 14, meaning the beat-count width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning the output beat FIFO depth (power of 2).
REQ-006 SHALL have port clk_i  in  1  the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-008 SHALL have port start_i  in  1  one-cycle job launch.
REQ-009 SHALL have port base_off_i  in  BANK_ADDR_WIDTH  first per-bank offset of the job.
REQ-010 SHALL have port num_beats_i  in  LEN_WIDTH  number of beats in the job; one beat is one word from each bank.
REQ-011 SHALL have port abort_i  in  1  cancels the job in progress.
REQ-012 SHALL have port busy_o  out  1  high while in FETCH or DRAIN.
REQ-013 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-014 SHALL have port err_o  out  1  sticky job error.
REQ-015 SHALL have port rd_en_o  out  NUM_BANKS  per-bank read enable to the weight buffer.
REQ-016 SHALL have port rd_addr_o  out  NUM_BANKS x (BANK_ADDR_WIDTH+log2 NUM_BANKS)  full read address per port.
REQ-017 SHALL have port rd_data_i  in  NUM_BANKS x DATA_WIDTH  buffer read data, valid in the same cycle as the request.
REQ-018 SHALL have port rd_valid_i  in  NUM_BANKS  per-bank read-valid from the buffer.
REQ-019 SHALL have port w_valid_o / w_ready_i  out / in  1 each  output beat handshake.
REQ-020 SHALL have port w_data_o  out  NUM_BANKS x DATA_WIDTH  output beat; lane b carries bank b.

Function
REQ-021 SHALL drive rd_addr_o[b] = {b, cur_off} for every port b, so each port hits only its own bank.
REQ-022 SHALL implement an FSM with states IDLE, FETCH, DRAIN, DONE.
REQ-023 In IDLE, on start_i, SHALL: clear err_o; latch cur_off=base_off_i and remaining=num_beats_i; then:
  - go to DONE when num_beats_i==0;
  - set err_o and go to DONE when base_off_i+num_beats_i > 2^BANK_ADDR_WIDTH (sum computed one bit wider), issuing no reads;
  - otherwise go to FETCH.
REQ-024 In FETCH, SHALL assert all rd_en_o bits in a cycle iff the FIFO is not full or a pop occurs in that cycle.
REQ-025 On an issued read, SHALL push rd_data_i into the FIFO, increment cur_off and decrement remaining in that same cycle.
REQ-026 When the read with remaining==1 is issued, SHALL go to DRAIN.
REQ-027 When an issued read has any rd_valid_i bit low, SHALL set err_o, push nothing and go to DRAIN.
REQ-028 In DRAIN, SHALL go to DONE on the cycle the FIFO becomes empty.
REQ-029 In DONE, SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-030 SHALL ignore start_i outside IDLE.
REQ-031 On abort_i in FETCH or DRAIN, SHALL flush the FIFO and go to IDLE the next cycle with no done_o; err_o is unchanged.
REQ-032 SHALL give abort_i priority over push, pop and start in the same cycle.
REQ-033 SHALL drive w_valid_o = FIFO not empty and w_data_o = FIFO head; a pop occurs when w_valid_o && w_ready_i.
REQ-034 SHALL allow a simultaneous push and pop when the FIFO is full, keeping the count unchanged.
REQ-035 SHALL keep the latency from read issue to w_valid_o at 1 cycle when the FIFO is empty.
REQ-036 SHALL hold w_data_o stable while w_valid_o && !w_ready_i.

Reset
REQ-037 On rst_i, SHALL enter IDLE and clear the FIFO pointers and count, cur_off and remaining.
REQ-038 During reset, SHALL drive busy_o, done_o, err_o, rd_en_o and w_valid_o to 0.
REQ-039 Reset mid-job SHALL discard all state with no done_o pulse; FIFO storage need not be cleared.

Structure
REQ-040 SHALL place the FSM state enum and the NUM_BANKS/DATA_WIDTH/BANK_ADDR_WIDTH defaults in package garuda_wbuf_pkg, shared with the weight buffer.
REQ-041 SHALL implement the beat FIFO as a sub-module wfetch_beat_fifo, parameterised by depth and width, with a push/pop/full/empty/count interface.

Verification
REQ-042 SHALL cover: base_off=0x10, num=3, ready held 1 -> reads at offsets 0x10, 0x11, 0x12 on consecutive cycles; 3 beats out; done_o pulses 2 cycles after the last beat.
REQ-043 SHALL cover: num=8 with ready held 0 -> exactly 4 reads, then rd_en_o low; raising ready resumes; all 8 beats out in order.
REQ-044 SHALL cover: base_off=0x1FFE, num=3 -> err_o=1, no rd_en_o, and done_o one cycle later.
REQ-045 SHALL cover: rd_valid_i[2]=0 on the 2nd read of num=5 -> err_o=1, 1 beat out, then done_o.
REQ-046 SHALL cover: abort_i in the 3rd FETCH cycle of num=10 -> IDLE the next cycle, w_valid_o=0, no done_o; a new start then succeeds.
REQ-047 SHALL cover: rst_i asserted mid-DRAIN -> all outputs 0 the next cycle; start_i is ignored while held in reset.
